// File: rtl/ls299.sv
// 74LS299-style universal shift/storage register: async clear, hold, shift right/left, parallel load.
// The parallel pins are released (Q_OE low) in load mode so they can be driven as inputs.

module ls299_cell (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [1:0] mode,
  input  logic       shr_in,
  input  logic       shl_in,
  input  logic       d,
  output logic       r_q
);
  logic r_d;

  // Unknown mode bits propagate X into the register instead of defaulting to hold.
  always_comb begin
    r_d = r_q;
    case (mode)
      2'b00:   r_d = r_q;
      2'b01:   r_d = shr_in;
      2'b10:   r_d = shl_in;
      2'b11:   r_d = d;
      default: r_d = 1'bx;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_q <= 1'b0;
    else      r_q <= r_d;
  end
endmodule

module ls299 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             S0,
  input  logic             S1,
  input  logic             SR,
  input  logic             SL,
  input  logic             OE1_n,
  input  logic             OE2_n,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Q_OE,
  output logic             QA_S,
  output logic             QH_S
);
  logic [WIDTH-1:0] r;
  // ext = {SL, R, SR}: bit i's right-shift source is ext[i], its left-shift source is ext[i+2].
  logic [WIDTH+1:0] ext;
  logic [1:0]       mode;

  assign mode = {S1, S0};
  assign ext  = {SL, r, SR};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ls299_cell u_cell (
      .CLK    (CLK),
      .CLR    (CLR),
      .mode   (mode),
      .shr_in (ext[i]),
      .shl_in (ext[i+2]),
      .d      (D[i]),
      .r_q    (r[i])
    );
  end

  assign Q_OE = !(S0 & S1) & !OE1_n & !OE2_n;
  assign Q    = Q_OE ? r : {WIDTH{1'bz}};
  assign QA_S = r[0];
  assign QH_S = r[WIDTH-1];
endmodule
